// File: rtl/uart_frame_tx_if.sv
// Transmit-side handshake between the frame sender (master) and the UART core (slave).
// T_Data must be stable for as long as T_nCS is low.
interface uart_frame_tx_if;
    logic       T_nCS;
    logic [7:0] T_Data;
    logic       T_Busy;

    modport master (output T_nCS, output T_Data, input T_Busy);
    modport slave  (input T_nCS, input T_Data, output T_Busy);
endinterface

// File: rtl/uart_frame_tx.sv
// Telemetry frame sender: snapshots four status words and streams a 12-byte frame
// (header, length, payload, checksum) into the UART core, one T_nCS strobe per byte.
module uart_frame_tx #(
    parameter logic [7:0]  HDR0       = 8'hA5,
    parameter logic [7:0]  HDR1       = 8'h5A,
    parameter int unsigned CS_LOW_CYC = 4,
    parameter int unsigned BUSY_TO    = 255
) (
    input  logic                   CLK_Uart16x,
    input  logic                   nRST,
    input  logic                   Start,
    input  logic [15:0]            Word0,
    input  logic [15:0]            Word1,
    input  logic [15:0]            Word2,
    input  logic [15:0]            Word3,
    output logic                   Frame_Busy,
    output logic                   Frame_Done,
    output logic                   Frame_Err,
    uart_frame_tx_if.master        tx
);

    localparam logic [7:0] LEN_BYTE = 8'h08;
    localparam logic [3:0] LAST_IDX = 4'd11;
    localparam logic [7:0] CS_LAST  = 8'(CS_LOW_CYC - 1);
    localparam logic [7:0] TO_LAST  = 8'(BUSY_TO - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CS_LOW,
        ST_WAIT_BH,
        ST_WAIT_BL,
        ST_NEXT,
        ST_ABORT
    } state_t;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [7:0]  csum_q;
    logic [7:0]  cnt_q;
    logic [63:0] snap_q;
    logic        ncs_q;
    logic [7:0]  data_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [3:0]  pay_idx;
    logic [5:0]  byte_off;
    logic [7:0]  byte_d;

    // Byte at the current frame index; payload is high byte of Word0 first.
    always_comb begin
        pay_idx  = idx_q - 4'd3;
        byte_off = {3'd7 - pay_idx[2:0], 3'b000};
        byte_d   = csum_q;
        case (idx_q)
            4'd0:    byte_d = HDR0;
            4'd1:    byte_d = HDR1;
            4'd2:    byte_d = LEN_BYTE;
            4'd11:   byte_d = csum_q;
            default: byte_d = snap_q[byte_off +: 8];
        endcase
    end

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; the snapshot is reset too so T_Data is never X.
    always_ff @(posedge CLK_Uart16x or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            ncs_q   <= 1'b1;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ncs_q <= 1'b1;
                    // A Start landing in the Frame_Done cycle is deliberately dropped.
                    if (Start && !done_q) begin
                        snap_q  <= {Word0, Word1, Word2, Word3};
                        idx_q   <= '0;
                        csum_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    data_q <= byte_d;
                    if (!tx.T_Busy) begin
                        ncs_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_CS_LOW;
                    end
                end
                ST_CS_LOW: begin
                    if (cnt_q == CS_LAST) begin
                        ncs_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_BH;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_WAIT_BH: begin
                    if (tx.T_Busy) begin
                        state_q <= ST_WAIT_BL;
                    end else if (cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ABORT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_WAIT_BL: begin
                    if (!tx.T_Busy) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx_q >= 4'd2 && idx_q <= 4'd10) begin
                        csum_q <= csum_q + byte_d;
                    end
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_ABORT: begin
                    ncs_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ncs_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.T_nCS   = ncs_q;
    assign tx.T_Data  = data_q;
    assign Frame_Busy = busy_q;
    assign Frame_Done = done_q;
    assign Frame_Err  = err_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with a behavioural UART-core responder on T_Busy.
// Byte streams, strobe widths and timing are compared against hand-computed values.
module tb_uart_frame_tx;

    localparam int BIT_CYC = 160;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
    logic        f_busy, f_done, f_err;
    logic        t_busy;
    logic        core_en = 1'b1;

    uart_frame_tx_if bus ();
    assign bus.T_Busy = t_busy;

    uart_frame_tx dut (
        .CLK_Uart16x (clk),
        .nRST        (nrst),
        .Start       (start),
        .Word0       (w0),
        .Word1       (w1),
        .Word2       (w2),
        .Word3       (w3),
        .Frame_Busy  (f_busy),
        .Frame_Done  (f_done),
        .Frame_Err   (f_err),
        .tx          (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART core stand-in: busy rises 3 cycles after the strobe falls, stays up one frame time.
    logic ncs_prev_r;
    int   core_cnt;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ncs_prev_r <= 1'b1;
            core_cnt   <= 0;
            t_busy     <= 1'b0;
        end else begin
            ncs_prev_r <= bus.T_nCS;
            if (core_cnt != 0) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt == 3) t_busy <= 1'b1;
                if (core_cnt == 3 + BIT_CYC) begin
                    t_busy   <= 1'b0;
                    core_cnt <= 0;
                end
            end else if (core_en && ncs_prev_r && !bus.T_nCS) begin
                core_cnt <= 1;
            end
        end
    end

    // Strobe monitor: captures each byte, its low width, data stability and output pulses.
    logic [7:0] rx_q[$];
    int         len_q[$];
    int         done_cnt = 0, err_cnt = 0, stab_bad = 0;
    logic       ncs_prev_m = 1'b1;
    int         low_len = 0;
    logic [7:0] cur_byte = '0;
    always @(negedge clk) begin
        if (ncs_prev_m && !bus.T_nCS) begin
            rx_q.push_back(bus.T_Data);
            cur_byte = bus.T_Data;
            low_len  = 1;
        end else if (!ncs_prev_m && !bus.T_nCS) begin
            low_len++;
            if (bus.T_Data !== cur_byte) stab_bad++;
        end else if (!ncs_prev_m && bus.T_nCS) begin
            len_q.push_back(low_len);
        end
        ncs_prev_m = bus.T_nCS;
        if (f_done) done_cnt++;
        if (f_err) err_cnt++;
    end

    task automatic clear_mon();
        rx_q.delete();
        len_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        stab_bad = 0;
    endtask

    // Sends one frame and checks it. inject_at >= 0 pulses Start with other words once that
    // many bytes have gone out; hit_done pulses Start in the Frame_Done cycle.
    task automatic run_frame(input string tag, input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2, input logic [15:0] a3,
                             input logic [7:0] exp_b [12], input int inject_at,
                             input bit hit_done);
        bit seen_done = 1'b0;
        bit injected  = 1'b0;
        clear_mon();
        @(negedge clk);
        w0 = a0; w1 = a1; w2 = a2; w3 = a3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 64'(f_busy), 64'd1);
        check({tag, " ncs_in_load"}, 64'(bus.T_nCS), 64'd1);
        @(negedge clk);
        check({tag, " ncs_first_low"}, 64'(bus.T_nCS), 64'd0);
        for (int c = 0; c < 6000 && !seen_done; c++) begin
            @(negedge clk);
            if (start) begin
                start = 1'b0;
            end else if (!injected && inject_at >= 0 && rx_q.size() == inject_at) begin
                w0 = 16'h1111; w1 = 16'h2222; w2 = 16'h3333; w3 = 16'h4444;
                start    = 1'b1;
                injected = 1'b1;
            end
            if (f_done) begin
                seen_done = 1'b1;
                check({tag, " busy_drops_with_done"}, 64'(f_busy), 64'd0);
            end
        end
        check({tag, " done_seen"}, 64'(seen_done), 64'd1);
        if (hit_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, " start_on_done_ignored"}, 64'(f_busy), 64'd0);
        end else begin
            @(negedge clk);
        end
        check({tag, " byte_count"}, 64'(rx_q.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("%s byte%0d", tag, i), 64'(rx_q[i]), 64'(exp_b[i]));
        for (int i = 0; i < 12; i++)
            check($sformatf("%s ncs_width%0d", tag, i), 64'(len_q[i]), 64'd4);
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " err_pulses"}, 64'(err_cnt), 64'd0);
        check({tag, " data_stable"}, 64'(stab_bad), 64'd0);
    endtask

    logic [7:0] exp_main [12] = '{8'hA5, 8'h5A, 8'h08, 8'h12, 8'h34, 8'h56,
                                  8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h40};
    logic [7:0] exp_zero [12] = '{8'hA5, 8'h5A, 8'h08, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
    logic [7:0] exp_ones [12] = '{8'hA5, 8'h5A, 8'h08, 8'hFF, 8'hFF, 8'hFF,
                                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] exp_alt  [12] = '{8'hA5, 8'h5A, 8'h08, 8'h11, 8'h11, 8'h22,
                                  8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h5C};

    initial begin
        int cyc;
        #1 nrst = 1'b0;
        #1;
        check("rst T_nCS", 64'(bus.T_nCS), 64'd1);
        check("rst T_Data", 64'(bus.T_Data), 64'h00);
        check("rst Frame_Busy", 64'(f_busy), 64'd0);
        check("rst Frame_Done", 64'(f_done), 64'd0);
        check("rst Frame_Err", 64'(f_err), 64'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        check("idle no strobes", 64'(rx_q.size()), 64'd0);
        check("idle T_nCS", 64'(bus.T_nCS), 64'd1);

        run_frame("main", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, exp_main, -1, 1'b0);
        run_frame("zeros", 16'h0000, 16'h0000, 16'h0000, 16'h0000, exp_zero, -1, 1'b0);
        run_frame("ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, exp_ones, -1, 1'b0);
        run_frame("restart", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, exp_main, 5, 1'b1);
        // Start one cycle after Frame_Done: words now hold 1111..4444 from the ignored pulse.
        run_frame("after_done", 16'h1111, 16'h2222, 16'h3333, 16'h4444, exp_alt, -1, 1'b0);

        // No core answering: timeout after the first strobe.
        core_en = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (bus.T_nCS && cyc < 20) begin @(negedge clk); cyc++; end
        check("to strobe_low", 64'(bus.T_nCS), 64'd0);
        cyc = 0;
        while (!bus.T_nCS && cyc < 20) begin @(negedge clk); cyc++; end
        check("to strobe_high", 64'(bus.T_nCS), 64'd1);
        cyc = 0;
        while (!f_err && cyc < 600) begin @(negedge clk); cyc++; end
        check("to err_delay", 64'(cyc), 64'd255);
        @(negedge clk);
        check("to T_nCS", 64'(bus.T_nCS), 64'd1);
        check("to busy_clear", 64'(f_busy), 64'd0);
        repeat (3) @(negedge clk);
        check("to err_pulses", 64'(err_cnt), 64'd1);
        check("to no_done", 64'(done_cnt), 64'd0);
        check("to strobes", 64'(rx_q.size()), 64'd1);
        core_en = 1'b1;

        // Reset while frame byte 7 is in flight.
        clear_mon();
        @(negedge clk);
        w0 = 16'h1234; w1 = 16'h5678; w2 = 16'h9ABC; w3 = 16'hDEF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rx_q.size() < 8 && cyc < 3000) begin @(negedge clk); cyc++; end
        check("mid reached_byte7", 64'(rx_q.size()), 64'd8);
        #2 nrst = 1'b0;
        #1;
        check("mid rst T_nCS", 64'(bus.T_nCS), 64'd1);
        check("mid rst Frame_Busy", 64'(f_busy), 64'd0);
        check("mid rst T_Data", 64'(bus.T_Data), 64'h00);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        run_frame("post_rst", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, exp_main, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
